// File: rtl/qr_finder_pkg.sv
// Shared widths, FSM encoding and cluster record for the finder row clustering stage.
package qr_finder_pkg;

    localparam int HEIGHT_DEF       = 480;
    localparam int IDX_W            = $clog2(HEIGHT_DEF);
    localparam int MAX_CLUSTERS_DEF = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        FSM_IDLE  = ST_IDLE,
        FSM_SCAN  = ST_SCAN,
        FSM_FLUSH = ST_FLUSH,
        FSM_DONE  = ST_DONE
    } cluster_fsm_t;

    typedef struct packed {
        logic [IDX_W-1:0] top;
        logic [IDX_W-1:0] bottom;
        logic [IDX_W-1:0] center;
    } cluster_t;

    // Midpoint computed with one extra bit so top+bottom cannot wrap.
    function automatic logic [IDX_W-1:0] row_mid(input logic [IDX_W-1:0] a,
                                                 input logic [IDX_W-1:0] b);
        logic [IDX_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[IDX_W:1];
    endfunction

endpackage

// File: rtl/finder_run_tracker.sv
// Tracks one open run of hit rows, tolerating short zero gaps, and pulses close with its extent.
module finder_run_tracker #(
    parameter int IDX_W   = 9,
    parameter int MAX_GAP = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             clear,
    input  logic             step,
    input  logic             flush,
    input  logic             row_bit,
    input  logic [IDX_W-1:0] idx,
    output logic             close,
    output logic [IDX_W-1:0] close_top,
    output logic [IDX_W-1:0] close_bottom
);

    localparam int GW = $clog2(MAX_GAP + 2);

    logic             in_run;
    logic [IDX_W-1:0] top;
    logic [IDX_W-1:0] last;
    logic [GW-1:0]    gap;
    logic             gap_full;

    assign gap_full     = (gap == GW'(MAX_GAP));
    assign close        = in_run & ((step & ~row_bit & gap_full) | flush);
    assign close_top    = top;
    assign close_bottom = last;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            in_run <= 1'b0;
            top    <= '0;
            last   <= '0;
            gap    <= '0;
        end else if (clear) begin
            in_run <= 1'b0;
            top    <= '0;
            last   <= '0;
            gap    <= '0;
        end else if (flush) begin
            in_run <= 1'b0;
            gap    <= '0;
        end else if (step) begin
            if (row_bit) begin
                if (!in_run) begin
                    top <= idx;
                end
                in_run <= 1'b1;
                last   <= idx;
                gap    <= '0;
            end else if (in_run) begin
                // The zero that would make the gap MAX_GAP+1 ends the run.
                if (gap_full) begin
                    in_run <= 1'b0;
                    gap    <= '0;
                end else begin
                    gap <= gap + GW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/finder_row_cluster.sv
// Groups finder-hit rows into vertical clusters, one row per cycle.
// Optional FINDER_CLUSTER_DROP_CNT_EN adds a saturating count of pulses ignored while busy.
module finder_row_cluster
    import qr_finder_pkg::*;
#(
    parameter int HEIGHT       = HEIGHT_DEF,
    parameter int MAX_GAP      = 2,
    parameter int MIN_RUN      = 3,
    parameter int MAX_CLUSTERS = MAX_CLUSTERS_DEF,
    localparam int IW          = $clog2(HEIGHT),
    localparam int CW          = $clog2(MAX_CLUSTERS + 1)
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [HEIGHT-1:0]          finder_encodings,
    input  logic                       data_valid_in,
    output logic                       busy_out,
    output logic                       done_out,
    output logic [CW-1:0]              cluster_count_out,
    output logic [MAX_CLUSTERS*IW-1:0] cluster_top_out,
    output logic [MAX_CLUSTERS*IW-1:0] cluster_bottom_out,
    output logic [MAX_CLUSTERS*IW-1:0] cluster_center_out,
`ifdef FINDER_CLUSTER_DROP_CNT_EN
    output logic [7:0]                 dropped_frames_out,
`endif
    output logic                       overflow_out
);

    cluster_fsm_t      state;
    logic [HEIGHT-1:0] shadow;
    logic [IW-1:0]     idx;
    cluster_t          slots [MAX_CLUSTERS];
    logic [CW-1:0]     count;
    logic              overflow;

    logic              start;
    logic              close;
    logic [IW-1:0]     close_top;
    logic [IW-1:0]     close_bottom;
    logic [IW:0]       span;
    logic              qualifies;

    assign start     = (state == FSM_IDLE) && data_valid_in;
    assign busy_out  = (state != FSM_IDLE);
    assign span      = {1'b0, close_bottom} - {1'b0, close_top} + (IW + 1)'(1);
    assign qualifies = close && (span >= (IW + 1)'(MIN_RUN));

    finder_run_tracker #(
        .IDX_W   (IW),
        .MAX_GAP (MAX_GAP)
    ) u_tracker (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .clear        (start),
        .step         (state == FSM_SCAN),
        .flush        (state == FSM_FLUSH),
        .row_bit      (shadow[0]),
        .idx          (idx),
        .close        (close),
        .close_top    (close_top),
        .close_bottom (close_bottom)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state              <= FSM_IDLE;
            shadow             <= '0;
            idx                <= '0;
            count              <= '0;
            overflow           <= 1'b0;
            done_out           <= 1'b0;
            cluster_count_out  <= '0;
            cluster_top_out    <= '0;
            cluster_bottom_out <= '0;
            cluster_center_out <= '0;
            overflow_out       <= 1'b0;
            for (int unsigned k = 0; k < MAX_CLUSTERS; k++) begin
                slots[k] <= '0;
            end
        end else begin
            done_out <= 1'b0;
            case (state)
                FSM_IDLE: begin
                    if (data_valid_in) begin
                        shadow   <= finder_encodings;
                        idx      <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                        for (int unsigned k = 0; k < MAX_CLUSTERS; k++) begin
                            slots[k] <= '0;
                        end
                        state <= FSM_SCAN;
                    end
                end
                FSM_SCAN: begin
                    // Shadow is consumed LSB first, so bit 0 is always the current row.
                    shadow <= shadow >> 1;
                    idx    <= idx + IW'(1);
                    if (idx == IW'(HEIGHT - 1)) begin
                        state <= FSM_FLUSH;
                    end
                end
                FSM_FLUSH: begin
                    state <= FSM_DONE;
                end
                FSM_DONE: begin
                    cluster_count_out <= count;
                    overflow_out      <= overflow;
                    for (int unsigned k = 0; k < MAX_CLUSTERS; k++) begin
                        cluster_top_out[k*IW +: IW]    <= slots[k].top;
                        cluster_bottom_out[k*IW +: IW] <= slots[k].bottom;
                        cluster_center_out[k*IW +: IW] <= slots[k].center;
                    end
                    done_out <= 1'b1;
                    state    <= FSM_IDLE;
                end
                default: state <= FSM_IDLE;
            endcase

            if (qualifies) begin
                if (count < CW'(MAX_CLUSTERS)) begin
                    slots[count].top    <= close_top;
                    slots[count].bottom <= close_bottom;
                    slots[count].center <= row_mid(close_top, close_bottom);
                    count               <= count + CW'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

`ifdef FINDER_CLUSTER_DROP_CNT_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            dropped_frames_out <= '0;
        end else if (data_valid_in && busy_out && (dropped_frames_out != 8'hFF)) begin
            dropped_frames_out <= dropped_frames_out + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_finder_row_cluster.sv
// Self-checking bench for finder_row_cluster: directed and random frames against a row-list model.
module tb_finder_row_cluster;

    localparam int H  = 480;
    localparam int MG = 2;
    localparam int MR = 3;
    localparam int MC = 3;
    localparam int IW = $clog2(H);
    localparam int CW = $clog2(MC + 1);

    logic              clk;
    logic              rst_n;
    logic [H-1:0]      finder;
    logic              dv;
    logic              busy;
    logic              done;
    logic [CW-1:0]     cnt_out;
    logic [MC*IW-1:0]  top_out;
    logic [MC*IW-1:0]  bot_out;
    logic [MC*IW-1:0]  ctr_out;
    logic              ovf_out;
`ifdef FINDER_CLUSTER_DROP_CNT_EN
    logic [7:0]        dropped;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_drop = 0;

    int m_cnt = 0;
    int m_ovf = 0;
    int m_top [MC];
    int m_bot [MC];

    logic [H-1:0] vec;
    int           done_seen;

    finder_row_cluster dut (
        .clk_in             (clk),
        .rst_in             (rst_n),
        .finder_encodings   (finder),
        .data_valid_in      (dv),
        .busy_out           (busy),
        .done_out           (done),
        .cluster_count_out  (cnt_out),
        .cluster_top_out    (top_out),
        .cluster_bottom_out (bot_out),
        .cluster_center_out (ctr_out),
`ifdef FINDER_CLUSTER_DROP_CNT_EN
        .dropped_frames_out (dropped),
`endif
        .overflow_out       (ovf_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void emit(input int t, input int b);
        if (b - t + 1 >= MR) begin
            if (m_cnt < MC) begin
                m_top[m_cnt] = t;
                m_bot[m_cnt] = b;
                m_cnt++;
            end else begin
                m_ovf = 1;
            end
        end
    endfunction

    // Hit rows whose separation leaves at most MG empty rows belong to one cluster.
    function automatic void model(input logic [H-1:0] v);
        int first;
        int prev;
        m_cnt = 0;
        m_ovf = 0;
        for (int k = 0; k < MC; k++) begin
            m_top[k] = 0;
            m_bot[k] = 0;
        end
        first = -1;
        prev  = -1;
        for (int r = 0; r < H; r++) begin
            if (v[r]) begin
                if (first < 0) begin
                    first = r;
                end else if (r - prev - 1 > MG) begin
                    emit(first, prev);
                    first = r;
                end
                prev = r;
            end
        end
        if (first >= 0) emit(first, prev);
    endfunction

    function automatic logic [H-1:0] rand_vec();
        logic [H-1:0] v;
        for (int i = 0; i < H; i += 32) begin
            v = {v[H-33:0], 32'($urandom)};
        end
        return v;
    endfunction

    task automatic set_rows(input int lo, input int hi);
        for (int r = lo; r <= hi && r < H; r++) vec[r] = 1'b1;
    endtask

    task automatic check_results();
        chk("count", 32'(cnt_out), 32'(m_cnt));
        chk("overflow", 32'(ovf_out), 32'(m_ovf));
        for (int k = 0; k < MC; k++) begin
            chk($sformatf("top%0d", k), 32'(top_out[k*IW +: IW]), 32'(m_top[k]));
            chk($sformatf("bottom%0d", k), 32'(bot_out[k*IW +: IW]), 32'(m_bot[k]));
            chk($sformatf("center%0d", k), 32'(ctr_out[k*IW +: IW]),
                32'((m_top[k] + m_bot[k]) / 2));
        end
    endtask

    task automatic run_frame(input logic [H-1:0] v, input bit inject);
        int cyc;
        int prev_cnt;
        prev_cnt = m_cnt;
        model(v);
        @(negedge clk);
        finder = v;
        dv     = 1'b1;
        @(negedge clk);
        dv     = 1'b0;
        finder = rand_vec();
        cyc    = 0;
        chk("busy_start", 32'(busy), 32'd1);
        while (done !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (inject && cyc == 30) begin
                dv     = 1'b1;
                finder = ~v;
                if (exp_drop < 255) exp_drop++;
            end else begin
                dv = 1'b0;
            end
            if (cyc == 100) chk("hold_count", 32'(cnt_out), 32'(prev_cnt));
        end
        chk("latency", 32'(cyc), 32'(H + 2));
        check_results();
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
`ifdef FINDER_CLUSTER_DROP_CNT_EN
        chk("dropped", 32'(dropped), 32'(exp_drop));
`endif
    endtask

    initial begin
        rst_n  = 1'b0;
        dv     = 1'b0;
        finder = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        check_results();
        rst_n = 1'b1;

        vec = '0; set_rows(100, 109);
        run_frame(vec, 1'b0);

        vec = '0; set_rows(100, 104); set_rows(107, 110);
        run_frame(vec, 1'b1);

        vec = '0; set_rows(100, 104); set_rows(108, 112);
        run_frame(vec, 1'b0);

        vec = '0; set_rows(200, 201);
        run_frame(vec, 1'b0);

        vec = '0; set_rows(10, 14); set_rows(50, 54); set_rows(90, 94); set_rows(130, 134);
        run_frame(vec, 1'b0);

        vec = '0; set_rows(477, 479); set_rows(0, 2);
        run_frame(vec, 1'b0);

        vec = '0; set_rows(477, 479);
        run_frame(vec, 1'b0);

        for (int f = 0; f < 6; f++) begin
            int r;
            int len;
            vec = '0;
            r = $urandom_range(0, 20);
            while (r < H) begin
                len = $urandom_range(1, 6);
                set_rows(r, r + len - 1);
                r += len + $urandom_range(1, 5) + ((f % 2 == 0) ? $urandom_range(0, 120) : 0);
            end
            run_frame(vec, f == 3);
        end

        // Abort a scan with reset after an ignored pulse.
        vec = '0; set_rows(20, 30);
        @(negedge clk);
        finder = vec;
        dv     = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        repeat (10) @(negedge clk);
        dv = 1'b1;
        if (exp_drop < 255) exp_drop++;
        @(negedge clk);
        dv = 1'b0;
`ifdef FINDER_CLUSTER_DROP_CNT_EN
        chk("dropped_busy", 32'(dropped), 32'(exp_drop));
`endif
        repeat (38) @(negedge clk);
        rst_n = 1'b0;
        exp_drop = 0;
        m_cnt = 0;
        m_ovf = 0;
        for (int k = 0; k < MC; k++) begin
            m_top[k] = 0;
            m_bot[k] = 0;
        end
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        check_results();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (H + 5) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        chk("no_done_after_abort", 32'(done_seen), 32'd0);
        chk("idle_after_abort", 32'(busy), 32'd0);

        vec = '0; set_rows(300, 305);
        run_frame(vec, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
